// File: rtl/tick_burst_sequencer_pkg.sv
// Shared definitions for the tick burst sequencer slice.
//   state_t          : sequencer state encoding (3 bits)
//   CNT_W_DEFAULT    : default counter / length width
//   TICK_PERIOD      : clock cycles between upstream tick_in strobes (bench use)
package tick_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;
  localparam int unsigned TICK_PERIOD   = 5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/tick_burst_sequencer_if.sv
// Request/status bundle between a burst requester and the tick burst sequencer.
//   start, high_len, low_len, burst_len : burst request (requester -> sequencer)
//   ready, busy, done, out, pulses_sent : status and waveform (sequencer -> requester)
//   abort / aborted                     : present only when TICK_BURST_ABORT_EN is defined
interface tick_burst_sequencer_if #(
  parameter int unsigned CNT_W = tick_pkg::CNT_W_DEFAULT
);

  logic             start;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] burst_len;
  logic             ready;
  logic             busy;
  logic             done;
  logic             out;
  logic [CNT_W-1:0] pulses_sent;
`ifdef TICK_BURST_ABORT_EN
  logic             abort;
  logic             aborted;

  modport master (
    output start, high_len, low_len, burst_len, abort,
    input  ready, busy, done, out, pulses_sent, aborted
  );

  modport slave (
    input  start, high_len, low_len, burst_len, abort,
    output ready, busy, done, out, pulses_sent, aborted
  );
`else
  modport master (
    output start, high_len, low_len, burst_len,
    input  ready, busy, done, out, pulses_sent
  );

  modport slave (
    input  start, high_len, low_len, burst_len,
    output ready, busy, done, out, pulses_sent
  );
`endif

endinterface

// File: rtl/tick_burst_sequencer_period_counter.sv
// Tick counter for one HIGH or LOW phase of the burst waveform.
//   clk, reset : clock, asynchronous active-high reset
//   load       : clear the count and capture limit (limit must be >= 1)
//   en         : one time-base tick elapsed
//   limit      : phase length in ticks
//   hit        : registered; the next enabled tick ends the phase
module tick_period_counter #(
  parameter int unsigned CNT_W = tick_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] limit_q;

  // hit is precomputed so the phase ends on the tick where count == limit-1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      limit_q <= ONE;
      hit     <= 1'b1;
    end else if (load) begin
      count   <= '0;
      limit_q <= limit;
      hit     <= (limit == ONE);
    end else if (en) begin
      if (hit) begin
        count <= '0;
        hit   <= (limit_q == ONE);
      end else begin
        count <= count + ONE;
        hit   <= ((count + ONE) == (limit_q - ONE));
      end
    end
  end

endmodule

// File: rtl/tick_burst_sequencer.sv
// Emits a burst of pulses on `out`, timed by the upstream tick_in strobe.
// Each pulse is high_len ticks high then low_len ticks low (0 treated as 1);
// burst_len pulses per request (0 = empty burst, done only).
//   clk, reset : clock, asynchronous active-high reset
//   tick_in    : 1-cycle time-base strobe
//   bus        : request/status bundle (slave side)
// Optional feature macro: TICK_BURST_ABORT_EN adds bus.abort / bus.aborted.
module tick_burst_sequencer
  import tick_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_in,
  tick_burst_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] high_q, high_nxt;
  logic [CNT_W-1:0] low_q, low_nxt;
  logic [CNT_W-1:0] burst_q, burst_nxt;
  logic [CNT_W-1:0] pulses_nxt;
  logic [CNT_W-1:0] pulses_inc;
  logic             out_nxt;
  logic             cnt_load;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_limit;
  logic             cnt_hit;
`ifdef TICK_BURST_ABORT_EN
  logic             aborted_nxt;
`endif

  tick_period_counter #(.CNT_W(CNT_W)) u_period (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .limit (cnt_limit),
    .hit   (cnt_hit)
  );

  // State, latched lengths and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      high_q          <= ONE;
      low_q           <= ONE;
      burst_q         <= '0;
      bus.out         <= 1'b0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
      bus.ready       <= 1'b1;
      bus.pulses_sent <= '0;
`ifdef TICK_BURST_ABORT_EN
      bus.aborted     <= 1'b0;
`endif
    end else begin
      state           <= state_nxt;
      high_q          <= high_nxt;
      low_q           <= low_nxt;
      burst_q         <= burst_nxt;
      bus.out         <= out_nxt;
      bus.done        <= (state_nxt == ST_DONE);
      bus.busy        <= (state_nxt == ST_SYNC) || (state_nxt == ST_HIGH) ||
                         (state_nxt == ST_LOW);
      bus.ready       <= (state_nxt == ST_IDLE);
      bus.pulses_sent <= pulses_nxt;
`ifdef TICK_BURST_ABORT_EN
      bus.aborted     <= aborted_nxt;
`endif
    end
  end

  // Next state, next outputs and phase counter control
  always_comb begin
    state_nxt  = state;
    high_nxt   = high_q;
    low_nxt    = low_q;
    burst_nxt  = burst_q;
    pulses_nxt = bus.pulses_sent;
    pulses_inc = bus.pulses_sent + ONE;
    out_nxt    = bus.out;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_limit  = high_q;
`ifdef TICK_BURST_ABORT_EN
    aborted_nxt = bus.aborted;
`endif

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          high_nxt   = (bus.high_len == '0) ? ONE : bus.high_len;
          low_nxt    = (bus.low_len  == '0) ? ONE : bus.low_len;
          burst_nxt  = bus.burst_len;
          pulses_nxt = '0;
`ifdef TICK_BURST_ABORT_EN
          aborted_nxt = 1'b0;
`endif
          state_nxt  = (bus.burst_len == '0) ? ST_DONE : ST_SYNC;
        end
      end
      ST_SYNC: begin
        // accept cycle is spent in IDLE, so its tick never reaches here
        if (tick_in) begin
          state_nxt = ST_HIGH;
          out_nxt   = 1'b1;
          cnt_load  = 1'b1;
          cnt_limit = high_q;
        end
      end
      ST_HIGH: begin
        if (tick_in) begin
          if (cnt_hit) begin
            out_nxt    = 1'b0;
            pulses_nxt = pulses_inc;
            if (pulses_inc == burst_q) begin
              state_nxt = ST_DONE;
            end else begin
              state_nxt = ST_LOW;
              cnt_load  = 1'b1;
              cnt_limit = low_q;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (tick_in) begin
          if (cnt_hit) begin
            state_nxt = ST_HIGH;
            out_nxt   = 1'b1;
            cnt_load  = 1'b1;
            cnt_limit = high_q;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        out_nxt   = 1'b0;
      end
    endcase

`ifdef TICK_BURST_ABORT_EN
    // abort wins over a coincident tick; the interrupted pulse is not counted
    if (bus.abort && ((state == ST_SYNC) || (state == ST_HIGH) || (state == ST_LOW))) begin
      state_nxt   = ST_DONE;
      out_nxt     = 1'b0;
      pulses_nxt  = bus.pulses_sent;
      aborted_nxt = 1'b1;
      cnt_load    = 1'b0;
      cnt_en      = 1'b0;
    end
`endif
  end

endmodule
